// File: rtl/display_driver_if.sv
// Digit inputs and scan/segment outputs of the four-digit seven-segment driver.
// The datapath side uses the master modport; the display driver uses the slave modport.
interface display_driver_if;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] scan;
    logic [6:0] disp;

    modport master (
        output dig0, dig1, dig2, dig3,
        input  scan, disp
    );

    modport slave (
        input  dig0, dig1, dig2, dig3,
        output scan, disp
    );
endinterface

// File: rtl/display_driver.sv
// Four-digit multiplexed seven-segment driver with registered, glitch-free scan/segment outputs.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module display_driver #(
    parameter int SCAN_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    display_driver_if.slave   bus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt_reg;
    logic [1:0]    idx_reg;
    logic [3:0]    scan_reg;
    logic [6:0]    disp_reg;

    logic [3:0]    digs [4];
    logic [3:0]    digit_sel;
    logic [3:0]    scan_next;
    logic [6:0]    seg_next;
    logic          blank;

    assign digs[0] = bus.dig0;
    assign digs[1] = bus.dig1;
    assign digs[2] = bus.dig2;
    assign digs[3] = bus.dig3;

    assign digit_sel = digs[idx_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scan
            assign scan_next[gi] = (idx_reg == 2'(gi));
        end
    endgenerate

`ifdef DISPLAY_LZB_EN
    logic [3:0] zero;
    logic [3:0] lead_zero;

    // A digit is blanked only if it and every digit to its left are zero; dig0 always shows.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lzb
            assign zero[gi] = (digs[gi] == 4'd0);
            if (gi == 0) begin : g_first
                assign lead_zero[gi] = 1'b0;
            end else begin : g_rest
                assign lead_zero[gi] = &zero[3:gi];
            end
        end
    endgenerate

    assign blank = lead_zero[idx_reg];
`else
    assign blank = 1'b0;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign seg_next = blank ? 7'h00 : seg_decode(digit_sel);

    // scan and disp come from the same idx on the same edge, so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            idx_reg     <= 2'd0;
            scan_reg    <= 4'b0000;
            disp_reg    <= 7'h00;
        end else begin
            scan_reg <= scan_next;
            disp_reg <= seg_next;
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                idx_reg     <= idx_reg + 2'd1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.scan = scan_reg;
    assign bus.disp = disp_reg;
endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench: two drivers (SCAN_DIV=1 and 4) share clock, reset and digits,
// and are compared every edge with a slot/blanking model derived from the edge count.
module tb_display_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] d [4];

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    display_driver_if bus1 ();
    display_driver_if bus4 ();

    assign bus1.dig0 = d[0];
    assign bus1.dig1 = d[1];
    assign bus1.dig2 = d[2];
    assign bus1.dig3 = d[3];
    assign bus4.dig0 = d[0];
    assign bus4.dig1 = d[1];
    assign bus4.dig2 = d[2];
    assign bus4.dig3 = d[3];

    display_driver #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    display_driver #(.SCAN_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    function automatic int m_slot(int div, int e);
        return ((e - 1) / div) % 4;
    endfunction

    function automatic logic [3:0] m_scan(int div, int e);
        logic [3:0] s;
        s = 4'b0000;
        if (e > 0) s[m_slot(div, e)] = 1'b1;
        return s;
    endfunction

    function automatic logic [6:0] m_disp(int div, int e);
        int  slot;
        bit  bl;
        if (e == 0) return 7'h00;
        slot = m_slot(div, e);
        bl = 1'b0;
`ifdef DISPLAY_LZB_EN
        if (slot > 0) begin
            bl = 1'b1;
            for (int j = slot; j < 4; j++) if (d[j] != 4'd0) bl = 1'b0;
        end
`endif
        return bl ? 7'h00 : SEG[d[slot]];
    endfunction

    // Advance one edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
    endtask

    task automatic test_reset();
        d[0] = 4'd0; d[1] = 4'd1; d[2] = 4'd2; d[3] = 4'd3;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (bus1.scan !== 4'b0000 || bus1.disp !== 7'h00) begin
            n_bad++;
            $display("FAIL reset_div1: scan=%b disp=%h want scan=0000 disp=00", bus1.scan, bus1.disp);
        end
        n_cmp++;
        if (bus4.scan !== 4'b0000 || bus4.disp !== 7'h00) begin
            n_bad++;
            $display("FAIL reset_div4: scan=%b disp=%h want scan=0000 disp=00", bus4.scan, bus4.disp);
        end
        $display("reset: scan1=%b disp1=%h scan4=%b disp4=%h", bus1.scan, bus1.disp, bus4.scan, bus4.disp);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
    endtask

    task automatic test_basic_sequence();
        logic [3:0] want_scan [5];
        logic [6:0] want_disp [5];
        want_scan = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        want_disp = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h3F};
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (bus1.scan !== want_scan[k] || bus1.disp !== want_disp[k]) begin
                n_bad++;
                $display("FAIL basic_edge%0d: scan=%b disp=%h want scan=%b disp=%h",
                         k + 1, bus1.scan, bus1.disp, want_scan[k], want_disp[k]);
            end
            n_cmp++;
            if (bus4.scan !== m_scan(4, edges) || bus4.disp !== m_disp(4, edges)) begin
                n_bad++;
                $display("FAIL basic_div4_edge%0d: scan=%b disp=%h want scan=%b disp=%h",
                         edges, bus4.scan, bus4.disp, m_scan(4, edges), m_disp(4, edges));
            end
            $display("basic edge %0d: scan=%b disp=%h", edges, bus1.scan, bus1.disp);
        end
    endtask

    task automatic test_sweep_dig0();
        d[1] = 4'd9; d[2] = 4'd4; d[3] = 4'd8;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            d[0] = 4'(v);
            for (int k = 0; k < 4; k++) begin
                tick();
                n_cmp++;
                if (bus1.scan !== m_scan(1, edges) || bus1.disp !== m_disp(1, edges)) begin
                    n_bad++;
                    $display("FAIL sweep_v%0h_edge%0d: scan=%b disp=%h want scan=%b disp=%h",
                             v, edges, bus1.scan, bus1.disp, m_scan(1, edges), m_disp(1, edges));
                end
            end
            $display("sweep dig0=%h: last scan=%b disp=%h", v, bus1.scan, bus1.disp);
        end
    endtask

    task automatic test_dwell_div4();
        logic [3:0] prev;
        int run;
        d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3; d[3] = 4'd4;
        do_reset();
        prev = 4'b0000;
        run = 0;
        for (int k = 0; k < 33; k++) begin
            tick();
            n_cmp++;
            if (bus4.scan !== m_scan(4, edges) || bus4.disp !== m_disp(4, edges)) begin
                n_bad++;
                $display("FAIL dwell_edge%0d: scan=%b disp=%h want scan=%b disp=%h",
                         edges, bus4.scan, bus4.disp, m_scan(4, edges), m_disp(4, edges));
            end
            if (bus4.scan === prev) begin
                run++;
            end else begin
                if (k > 0) begin
                    n_cmp++;
                    if (run != 4) begin
                        n_bad++;
                        $display("FAIL dwell_len: scan %b held %0d edges want 4", prev, run);
                    end
                end
                prev = bus4.scan;
                run = 1;
            end
        end
        $display("dwell: 33 edges checked, final scan=%b", bus4.scan);
    endtask

    task automatic test_mid_reset();
        d[0] = 4'd7; d[1] = 4'd3; d[2] = 4'd5; d[3] = 4'd2;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (bus4.scan !== 4'b0100) begin
            n_bad++;
            $display("FAIL midreset_pre: scan=%b want 0100", bus4.scan);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus4.scan !== 4'b0000 || bus4.disp !== 7'h00 || bus1.scan !== 4'b0000 || bus1.disp !== 7'h00) begin
            n_bad++;
            $display("FAIL midreset_async: scan4=%b disp4=%h scan1=%b disp1=%h want all 0",
                     bus4.scan, bus4.disp, bus1.scan, bus1.disp);
        end
        #1;
        rst_n = 1'b1;
        edges = 0;
        tick();
        n_cmp++;
        if (bus4.scan !== 4'b0001 || bus4.disp !== SEG[7] || bus1.scan !== 4'b0001) begin
            n_bad++;
            $display("FAIL midreset_restart: scan4=%b disp4=%h scan1=%b want 0001 %h 0001",
                     bus4.scan, bus4.disp, bus1.scan, SEG[7]);
        end
        $display("mid-reset: restart scan4=%b disp4=%h", bus4.scan, bus4.disp);
    endtask

    task automatic test_live_change();
        d[0] = 4'd1; d[1] = 4'd1; d[2] = 4'd6; d[3] = 4'd9;
        do_reset();
        for (int k = 0; k < 9; k++) tick();
        n_cmp++;
        if (bus4.scan !== 4'b0100 || bus4.disp !== 7'h7D) begin
            n_bad++;
            $display("FAIL live_before: scan=%b disp=%h want 0100 7d", bus4.scan, bus4.disp);
        end
        d[2] = 4'd7;
        tick();
        n_cmp++;
        if (bus4.scan !== 4'b0100 || bus4.disp !== 7'h07) begin
            n_bad++;
            $display("FAIL live_after: scan=%b disp=%h want 0100 07", bus4.scan, bus4.disp);
        end
        $display("live change: scan=%b disp=%h", bus4.scan, bus4.disp);
    endtask

    task automatic test_blanking();
        logic [3:0] pat [2][4];
        pat = '{'{4'd5, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd1, 4'd0}};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) d[i] = pat[p][i];
            do_reset();
            for (int k = 0; k < 4; k++) begin
                tick();
                n_cmp++;
                if (bus1.scan !== m_scan(1, edges) || bus1.disp !== m_disp(1, edges)) begin
                    n_bad++;
                    $display("FAIL blank_p%0d_slot%0d: scan=%b disp=%h want scan=%b disp=%h",
                             p, k, bus1.scan, bus1.disp, m_scan(1, edges), m_disp(1, edges));
                end
                $display("blank pattern %0d slot %0d: disp=%h", p, k, bus1.disp);
            end
        end
`ifdef DISPLAY_LZB_EN
        // Last pattern is dig3..0 = 0,1,0,0: slot 3 is blank, slot 2 shows 1.
        n_cmp++;
        if (bus1.disp !== 7'h00) begin
            n_bad++;
            $display("FAIL blank_slot3: disp=%h want 00", bus1.disp);
        end
`else
        n_cmp++;
        if (bus1.disp !== 7'h3F) begin
            n_bad++;
            $display("FAIL noblank_slot3: disp=%h want 3f", bus1.disp);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < 4; i++) begin
                d[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            tick();
            n_cmp++;
            if (bus1.scan !== m_scan(1, edges) || bus1.disp !== m_disp(1, edges)) begin
                n_bad++;
                $display("FAIL random_div1_edge%0d: scan=%b disp=%h want scan=%b disp=%h",
                         edges, bus1.scan, bus1.disp, m_scan(1, edges), m_disp(1, edges));
            end
            n_cmp++;
            if (bus4.scan !== m_scan(4, edges) || bus4.disp !== m_disp(4, edges)) begin
                n_bad++;
                $display("FAIL random_div4_edge%0d: scan=%b disp=%h want scan=%b disp=%h",
                         edges, bus4.scan, bus4.disp, m_scan(4, edges), m_disp(4, edges));
            end
        end
        $display("random: 200 edges, digits now %h%h%h%h", d[3], d[2], d[1], d[0]);
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_sweep_dig0();
        test_dwell_div4();
        test_mid_reset();
        test_live_change();
        test_blanking();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
